// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}, entry n is the glyph for hex n.
  localparam logic [15:0][6:0] SEG_CODE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef struct packed {
    logic       dp;
    logic [3:0] value;
  } digit_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_CODE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed seven-segment scan controller with frame-synchronous bank swap.
// Optional inter-digit blanking is enabled by defining SEG_SCAN_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic       WR_EN,
  input  logic [1:0] WR_ADDR,
  input  logic [3:0] WR_DATA,
  input  logic       WR_DP,
  input  logic       COMMIT,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [1:0] SCAN_IDX,
  output logic       FRAME_TICK,
  output logic       COMMIT_PENDING
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(PRESCALE - 1);
`ifdef SEG_SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pending;
  logic             boundary, transfer;
  digit_t           shadow [4];
  digit_t           active [4];
  digit_t           disp_n;
  logic [6:0]       seg_dec;
  logic [3:0]       an_n;
  logic [6:0]       seg_n;
  logic             dp_n;

  assign boundary = (state == SCAN) && (idx == 2'd3) && (cnt == SLOT_LAST);
  assign transfer = (boundary || (state == IDLE)) && (pending || COMMIT);

  // Drive the glyph from the bank as it will be after this edge, so a swap shows at once.
  assign disp_n = transfer ? shadow[idx_n] : active[idx_n];

  seg_hex_decode u_dec (
    .hex (disp_n.value),
    .seg (seg_dec)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      idx     <= 2'd0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      pending <= transfer ? 1'b0 : (pending | COMMIT);
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    if (!ENABLE) begin
      state_n = IDLE;
      idx_n   = 2'd0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SCAN;
          idx_n   = 2'd0;
          cnt_n   = '0;
        end
        SCAN: begin
          if (cnt == SLOT_LAST) begin
            cnt_n = '0;
`ifdef SEG_SCAN_BLANK_EN
            state_n = BLANK;
`else
            idx_n = idx + 2'd1;
`endif
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
`ifdef SEG_SCAN_BLANK_EN
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = SCAN;
            idx_n   = idx + 2'd1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
`endif
        default: begin
          state_n = IDLE;
          idx_n   = 2'd0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    an_n  = AN_OFF;
    seg_n = SEG_OFF;
    dp_n  = 1'b1;
    if (state_n == SCAN) begin
      an_n  = ~(4'b0001 << idx_n);
      seg_n = seg_dec;
      dp_n  = ~disp_n.dp;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      AN         <= AN_OFF;
      SEG        <= SEG_OFF;
      DP         <= 1'b1;
      FRAME_TICK <= 1'b0;
    end else begin
      AN         <= an_n;
      SEG        <= seg_n;
      DP         <= dp_n;
      FRAME_TICK <= boundary;
    end
  end

  // A transfer reads the shadow before this edge's write lands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (WR_EN) shadow[WR_ADDR] <= {WR_DP, WR_DATA};
      if (transfer) begin
        for (int i = 0; i < 4; i++) active[i] <= shadow[i];
      end
    end
  end

  assign SCAN_IDX       = idx;
  assign COMMIT_PENDING = pending;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. It holds four digit values with decimal points and steps a one-hot anode ring across the digits at a programmable rate. It decodes hex to segments and swaps newly written values in only at frame boundaries, so partial updates never show. It sits between the lab datapath, which writes values, and the display pins.

## Interface
- PRESCALE, default 50000: CLK cycles per digit slot; legal range ≥2.
- BLANK_CYCLES, default 8: inter-digit blank length in cycles; ≥1; used only with SEG_SCAN_BLANK_EN.
- Clock is CLK; reset is RST, asynchronous, active-high.
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- ENABLE  in  1  scan enable; low blanks the display
- WR_EN  in  1  write strobe into the shadow bank
- WR_ADDR  in  2  digit index for the write
- WR_DATA  in  4  hex value for the write
- WR_DP  in  1  decimal point for the write, 1 = lit
- COMMIT  in  1  one-cycle request to copy the shadow bank to the active bank
- AN  out  4  anodes, active-low one-hot; AN[i]=0 lights digit i
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low
- DP  out  1  decimal point, active-low
- SCAN_IDX  out  2  digit currently driven
- FRAME_TICK  out  1  one-cycle pulse on the frame boundary
- COMMIT_PENDING  out  1  a commit is requested but not yet applied

## Operation
- Reset values:
  - AN=4'b1111, SEG=7'b1111111, DP=1, SCAN_IDX=0, FRAME_TICK=0, COMMIT_PENDING=0.
  - Shadow and active banks: all digits 0 with DP off. State IDLE. Prescaler 0.
- States: IDLE, SCAN, and BLANK (BLANK exists only with the macro).
  - IDLE: all outputs off, prescaler held at 0, SCAN_IDX=0.
  - IDLE→SCAN when ENABLE=1. The next edge drives digit 0.
  - SCAN: AN[SCAN_IDX]=0; SEG and DP are decoded from active[SCAN_IDX]. The prescaler counts 0..PRESCALE-1.
  - On the last cycle of a slot (count=PRESCALE-1), the next edge advances SCAN_IDX 0→1→2→3→0 and resets the prescaler.
- ENABLE=0 in any state: the next edge goes to IDLE. This works mid-slot and needs no wait for the boundary.
- Frame boundary: the last cycle of the digit-3 slot while in SCAN. FRAME_TICK=1 on the edge that leaves that slot.
- Writes:
  - WR_EN=1 writes shadow[WR_ADDR] <= {WR_DP, WR_DATA} on the edge.
  - Writes are always accepted; there is no backpressure.
- Commit:
  - COMMIT sets COMMIT_PENDING.
  - Transfer condition: (frame boundary or state IDLE) and (COMMIT_PENDING or COMMIT).
  - On transfer: active <= shadow and COMMIT_PENDING <= 0, on the same edge.
  - A COMMIT that arrives on the boundary cycle or in IDLE is applied on that same edge and never raises pending.
- Simultaneous WR_EN and transfer: the transfer copies the pre-write shadow. The new write stays in shadow until the next commit.
- Decode, hex to SEG:
  - 0:1000000  1:1111001  2:0100100  3:0110000
  - 4:0011001  5:0010010  6:0000010  7:1111000
  - 8:0000000  9:0010000  A:0001000  b:0000011
  - C:1000110  d:0100001  E:0000110  F:0001110

## Timing
- All outputs are registered.
- AN, SEG, DP, SCAN_IDX and FRAME_TICK update on the same edge.
- Digit period is PRESCALE cycles. Frame period is 4·PRESCALE cycles without the macro, and 4·(PRESCALE+BLANK_CYCLES) with it.
- Write-to-display latency: the write is visible from the first slot after the transfer edge, i.e. at most one frame after COMMIT.
- RST mid-frame forces reset values immediately (asynchronously). Scanning resumes at digit 0 one edge after RST deasserts, provided ENABLE=1.

## Configuration
- SEG_SCAN_BLANK_EN defined (ghosting suppression):
  - After each SCAN slot, enter BLANK for BLANK_CYCLES cycles with AN=4'b1111 and SEG=7'b1111111, then SCAN the next digit.
  - The frame boundary remains the last SCAN cycle of digit 3, not the end of the following blank.
  - ENABLE=0 during BLANK goes to IDLE.
- Undefined: no BLANK state; SCAN slots are back to back and BLANK_CYCLES is ignored.

## Structure
- Package seg_scan_pkg contains:
  - the state enum (IDLE, SCAN, BLANK);
  - the 16-entry segment code constants;
  - AN_OFF=4'b1111 and SEG_OFF=7'b1111111;
  - a digit entry typedef {dp, value[3:0]}.
- Sub-module seg_hex_decode: combinational, 4-bit hex in, 7-bit active-low SEG out.
- The prescaler, the FSM, both banks and the commit logic live in seg_scan_ctrl.

## Test plan
All scenarios use PRESCALE=4 and BLANK_CYCLES=2.
- Reset then ENABLE=1: AN sequence 1110,1101,1011,0111, each held for 4 cycles, repeating. FRAME_TICK pulses every 16 cycles. SEG=1000000 throughout.
- Write digits 1,2,3,4 with DP on digit 2, then COMMIT mid-frame:
  - COMMIT_PENDING=1 until the next boundary, then 0.
  - Next frame shows 1111001, 0100100, 0110000, 0011001, with DP=0 only on digit 2.
- WR_EN to digit 0 on the same cycle as a boundary transfer: the displayed digit 0 keeps the old value; a second COMMIT shows the new value.
- ENABLE=0 mid-slot of digit 2: the next edge gives AN=1111 and SCAN_IDX=0. A COMMIT while idle clears pending within 1 cycle.
- Assert RST asynchronously mid-frame: outputs take reset values immediately, both banks read back 0, and scanning restarts at digit 0.
- With SEG_SCAN_BLANK_EN: 2 cycles of AN=1111 between digits, and a frame period of 24 cycles.
